// File: rtl/hue_sector_div_pkg.sv
// hue_pkg: shared types and constants for the HSV hue engine.
// FSM states, channel indices, sector base and hue wrap helpers.
package hue_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DIV,
    DONE
  } hue_state_e;

  localparam logic [1:0] IDX_R = 2'd0;
  localparam logic [1:0] IDX_G = 2'd1;
  localparam logic [1:0] IDX_B = 2'd2;

  localparam int HUE_FRAC_W = 8;

  // Sector start in hue units: R=0, G=2, B=4 sectors.
  function automatic int unsigned sector_base(
    input logic [1:0] idx,
    input int         frac_w
  );
    return (32'(idx) << 1) << frac_w;
  endfunction

  // One full turn (six sectors) in hue units.
  function automatic int unsigned hue_wrap(input int frac_w);
    return 32'd6 << frac_w;
  endfunction

  localparam int unsigned HUE_WRAP = 32'd6 << HUE_FRAC_W;

endpackage

// File: rtl/hue_restoring_div.sv
// hue_restoring_div: restoring divider, one quotient bit per cycle.
// start/dividend/divisor in; busy, done (final iteration), quotient out.
module hue_restoring_div #(
  parameter int DATA_W = 10,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W:0]   dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic              busy,
  output logic              done,
  output logic [FRAC_W:0]   quotient
);

  localparam int CNT_W = $clog2(FRAC_W + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAC_W);

  logic [DATA_W:0]   rem_q, rem_d;
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic [FRAC_W-1:0] quo_q, quo_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              busy_q, busy_d;

  logic [DATA_W:0] sub;
  logic [DATA_W:0] keep;
  logic            ge;

  // Partial remainder starts at |diff|: the quotient never exceeds
  // 2^FRAC_W, so the bits above FRAC_W are known to be zero.
  assign ge   = rem_q >= {1'b0, dvs_q};
  assign sub  = rem_q - {1'b0, dvs_q};
  assign keep = ge ? sub : rem_q;

  always_comb begin
    rem_d  = rem_q;
    dvs_d  = dvs_q;
    quo_d  = quo_q;
    cnt_d  = cnt_q;
    busy_d = busy_q;
    if (start) begin
      rem_d  = dividend;
      dvs_d  = divisor;
      quo_d  = '0;
      cnt_d  = '0;
      busy_d = 1'b1;
    end else if (busy_q) begin
      rem_d = keep << 1;
      quo_d = {quo_q[FRAC_W-2:0], ge};
      cnt_d = cnt_q + 1'b1;
      if (cnt_q == LAST) busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rem_q  <= '0;
      dvs_q  <= '0;
      quo_q  <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      rem_q  <= rem_d;
      dvs_q  <= dvs_d;
      quo_q  <= quo_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
    end
  end

  assign busy     = busy_q;
  assign done     = busy_q && (cnt_q == LAST);
  assign quotient = {quo_q, ge};

endmodule

// File: rtl/hue_sector_div.sv
// hue_sector_div: RGB pixel -> HSV hue in 60-degree sector units.
// in_valid/in_ready pixel in; out_valid/out_ready hue, chroma, value.
module hue_sector_div
  import hue_pkg::*;
#(
  parameter int DATA_W = 10,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] red,
  input  logic [DATA_W-1:0] green,
  input  logic [DATA_W-1:0] blue,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [FRAC_W+2:0] hue,
  output logic [DATA_W-1:0] chroma,
  output logic [DATA_W-1:0] value,
  output logic [1:0]        max_index,
  output logic              gray
);

  localparam int HUE_W = FRAC_W + 3;

  hue_state_e state_q, state_d;

  logic [DATA_W-1:0] red_q, red_d;
  logic [DATA_W-1:0] grn_q, grn_d;
  logic [DATA_W-1:0] blu_q, blu_d;
  logic [HUE_W-1:0]  hue_q, hue_d;
  logic [DATA_W-1:0] chr_q, chr_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [1:0]        idx_q, idx_d;
  logic              gray_q, gray_d;
  logic              neg_q, neg_d;

  logic              r_max, g_max;
  logic [DATA_W-1:0] mx_s, mn_s, chr_s;
  logic [1:0]        idx_s;
  logic [DATA_W:0]   diff_s, mag_s;

  logic              dv_start, dv_busy, dv_done;
  logic [FRAC_W:0]   dv_quo;
  logic [HUE_W-1:0]  q_ext, base, hue_asm;

  assign r_max = (red_q >= grn_q) && (red_q >= blu_q);
  assign g_max = !r_max && (grn_q >= blu_q);

  always_comb begin
    mx_s   = blu_q;
    idx_s  = IDX_B;
    diff_s = {1'b0, red_q} - {1'b0, grn_q};
    unique case (1'b1)
      r_max: begin
        mx_s   = red_q;
        idx_s  = IDX_R;
        diff_s = {1'b0, grn_q} - {1'b0, blu_q};
      end
      g_max: begin
        mx_s   = grn_q;
        idx_s  = IDX_G;
        diff_s = {1'b0, blu_q} - {1'b0, red_q};
      end
      default: ;
    endcase
    mn_s = red_q;
    if (grn_q < mn_s) mn_s = grn_q;
    if (blu_q < mn_s) mn_s = blu_q;
  end

  assign chr_s = mx_s - mn_s;
  assign mag_s = diff_s[DATA_W] ? -diff_s : diff_s;

  assign dv_start = (state_q == SORT) && (chr_s != '0);

  hue_restoring_div #(
    .DATA_W (DATA_W),
    .FRAC_W (FRAC_W)
  ) u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (dv_start),
    .dividend (mag_s),
    .divisor  (chr_s),
    .busy     (dv_busy),
    .done     (dv_done),
    .quotient (dv_quo)
  );

  // Negative offset in the red sector wraps below 6 sectors;
  // q==0 there must land on 0, not on the full turn.
  always_comb begin
    q_ext = HUE_W'(dv_quo);
    base  = HUE_W'(sector_base(idx_q, FRAC_W));
    if (!neg_q) hue_asm = base + q_ext;
    else if (idx_q != IDX_R) hue_asm = base - q_ext;
    else if (dv_quo == '0) hue_asm = '0;
    else hue_asm = HUE_W'(hue_wrap(FRAC_W)) - q_ext;
  end

  assign in_ready = (state_q == IDLE) ||
                    ((state_q == DONE) && out_ready);

  always_comb begin
    state_d = state_q;
    red_d   = red_q;
    grn_d   = grn_q;
    blu_d   = blu_q;
    hue_d   = hue_q;
    chr_d   = chr_q;
    val_d   = val_q;
    idx_d   = idx_q;
    gray_d  = gray_q;
    neg_d   = neg_q;
    if (in_valid && in_ready) begin
      red_d = red;
      grn_d = green;
      blu_d = blue;
    end
    unique case (state_q)
      IDLE: if (in_valid) state_d = SORT;
      SORT: begin
        chr_d  = chr_s;
        val_d  = mx_s;
        idx_d  = idx_s;
        neg_d  = diff_s[DATA_W];
        gray_d = (chr_s == '0);
        if (chr_s == '0) begin
          hue_d   = '0;
          state_d = DONE;
        end else begin
          state_d = DIV;
        end
      end
      DIV: if (dv_done) begin
        hue_d   = hue_asm;
        state_d = DONE;
      end
      DONE: if (out_ready) state_d = in_valid ? SORT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      red_q   <= '0;
      grn_q   <= '0;
      blu_q   <= '0;
      hue_q   <= '0;
      chr_q   <= '0;
      val_q   <= '0;
      idx_q   <= '0;
      gray_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      red_q   <= red_d;
      grn_q   <= grn_d;
      blu_q   <= blu_d;
      hue_q   <= hue_d;
      chr_q   <= chr_d;
      val_q   <= val_d;
      idx_q   <= idx_d;
      gray_q  <= gray_d;
      neg_q   <= neg_d;
    end
  end

  assign out_valid = (state_q == DONE);
  assign hue       = hue_q;
  assign chroma    = chr_q;
  assign value     = val_q;
  assign max_index = idx_q;
  assign gray      = gray_q;

endmodule

// File: tb/tb_hue_sector_div.sv
// tb_hue_sector_div: directed vectors for hue_sector_div.
// Hand-computed hue/chroma/value/index/gray and latency.
module tb_hue_sector_div;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [9:0] red = '0, green = '0, blue = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [10:0] hue;
  logic [9:0] chroma, value;
  logic [1:0] max_index;
  logic       gray;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  hue_sector_div #(.DATA_W(10), .FRAC_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .red       (red),
    .green     (green),
    .blue      (blue),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .hue       (hue),
    .chroma    (chroma),
    .value     (value),
    .max_index (max_index),
    .gray      (gray)
  );

  typedef struct {
    int r, g, b, h, c, v, idx, gr, lat;
  } vec_t;

  vec_t vecs [0:10] = '{
    '{1023,    0,    0,    0, 1023, 1023, 0, 0, 11},
    '{   0, 1023,    0,  512, 1023, 1023, 1, 0, 11},
    '{   0,    0, 1023, 1024, 1023, 1023, 2, 0, 11},
    '{1023,    0,  512, 1408, 1023, 1023, 0, 0, 11},
    '{ 600,  600,  100,  256,  500,  600, 0, 0, 11},
    '{ 512,  512,  512,    0,    0,  512, 0, 1,  2},
    '{ 100,   50,  200, 1109,  150,  200, 2, 0, 11},
    '{ 600,  900,  300,  384,  600,  900, 1, 0, 11},
    '{1000,    0,    1,    0, 1000, 1000, 0, 0, 11},
    '{   0,  600,  900,  854,  900,  900, 2, 0, 11},
    '{ 900,    0,  900, 1280,  900,  900, 0, 0, 11}
  };

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Called right after the accept edge; lat=1 is the cycle after it.
  task automatic wait_out(output int lat);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
  endtask

  task automatic send(input int r, input int g, input int b);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", int'(in_ready), 1);
    red = 10'(r); green = 10'(g); blue = 10'(b);
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic check_out(input string tag, input vec_t v, input int lat);
    check({tag, ".lat"}, lat, v.lat);
    check({tag, ".hue"}, int'(hue), v.h);
    check({tag, ".chroma"}, int'(chroma), v.c);
    check({tag, ".value"}, int'(value), v.v);
    check({tag, ".idx"}, int'(max_index), v.idx);
    check({tag, ".gray"}, int'(gray), v.gr);
  endtask

  task automatic consume;
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    vec_t bp;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst.out_valid", int'(out_valid), 0);
    check("rst.in_ready", int'(in_ready), 1);
    check("rst.hue", int'(hue), 0);
    check("rst.chroma", int'(chroma), 0);
    check("rst.value", int'(value), 0);
    check("rst.idx", int'(max_index), 0);
    check("rst.gray", int'(gray), 0);

    for (int i = 0; i < 11; i++) begin
      send(vecs[i].r, vecs[i].g, vecs[i].b);
      wait_out(lat);
      check_out($sformatf("v%0d", i), vecs[i], lat);
      consume();
    end

    // Backpressure: hold result, offer a pixel that must be ignored.
    send(vecs[6].r, vecs[6].g, vecs[6].b);
    wait_out(lat);
    check_out("bp0", vecs[6], lat);
    red = 10'd1023; green = 10'd0; blue = 10'd512;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check("bp.in_ready", int'(in_ready), 0);
      check("bp.out_valid", int'(out_valid), 1);
      check("bp.hue", int'(hue), vecs[6].h);
      check("bp.chroma", int'(chroma), vecs[6].c);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 check("bp.accept_ready", int'(in_ready), 1);
    @(posedge clk);
    #1 begin
      out_ready = 1'b0;
      in_valid = 1'b0;
    end
    wait_out(lat);
    bp = vecs[3];
    check_out("bp1", bp, lat);
    consume();

    // Reset four cycles into the divide.
    send(1023, 0, 0);
    repeat (5) @(posedge clk);
    #1 check("mid.out_valid_pre", int'(out_valid), 0);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid.out_valid", int'(out_valid), 0);
    check("mid.in_ready", int'(in_ready), 1);
    send(vecs[1].r, vecs[1].g, vecs[1].b);
    wait_out(lat);
    check_out("post_rst", vecs[1], lat);
    consume();

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
